// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite position register bank.
package sprite_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int DATA_W_DEF  = 2 * COORD_W_DEF;
  localparam int H_MAX_DEF   = 639;
  localparam int V_MAX_DEF   = 479;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] x;
  } sprite_pos_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/sprite_coord_clamp.sv
// Combinational saturation of a packed {Y, X} sprite position to the
// visible screen limits; used on the shadow write path.
module sprite_coord_clamp #(
  parameter int  COORD_W = 16,
  parameter int  H_MAX   = 639,
  parameter int  V_MAX   = 479,
  localparam int DATA_W  = 2 * COORD_W
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_MAX);

  logic [COORD_W-1:0] x_in;
  logic [COORD_W-1:0] y_in;

  assign x_in = din[COORD_W-1:0];
  assign y_in = din[DATA_W-1:COORD_W];

  assign dout = {(y_in > Y_LIM) ? Y_LIM : y_in,
                 (x_in > X_LIM) ? X_LIM : x_in};

endmodule

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite position bank: CPU writes the shadow bank, a commit
// publishes it to the active bank on the next vsync rising edge.
// Optional write-path clamp to H_MAX/V_MAX: `define SPRITE_COORD_CLAMP_EN.
module sprite_reg_bank
  import sprite_pkg::*;
#(
  parameter int  NUM_SPRITES = 8,
  parameter int  COORD_W     = COORD_W_DEF,
  parameter int  H_MAX       = H_MAX_DEF,
  parameter int  V_MAX       = V_MAX_DEF,
  localparam int ADDR_W      = $clog2(NUM_SPRITES),
  localparam int DATA_W      = 2 * COORD_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wd,
  input  logic                   commit_req,
  input  logic                   vsync,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [DATA_W-1:0]      rd1,
  output logic [DATA_W-1:0]      rd2,
  output logic                   commit_pending,
  output logic [NUM_SPRITES-1:0] dirty_mask,
  output logic                   wr_err
);

  // Read array is padded to the full address space so out-of-range reads see 0.
  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_V      = (ADDR_W + 1)'(NUM_SPRITES);
  localparam logic [0:0]      ST_IDLE    = IDLE;
  localparam logic [0:0]      ST_PENDING = PENDING;

  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic              vsync_q_reg;
  logic              wr_err_reg;
  logic              addr_ok;
  logic              wr_ok;
  logic              frame_edge;
  logic              do_commit;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] active_arr [DEPTH];

  assign addr_ok    = ({1'b0, waddr} < NUM_V);
  assign wr_ok      = we && addr_ok;
  assign frame_edge = vsync && !vsync_q_reg;
  assign do_commit  = (state_reg == ST_PENDING) && frame_edge;

`ifdef SPRITE_COORD_CLAMP_EN
  sprite_coord_clamp #(
    .COORD_W (COORD_W),
    .H_MAX   (H_MAX),
    .V_MAX   (V_MAX)
  ) u_clamp (
    .din  (wd),
    .dout (wdata)
  );
`else
  assign wdata = wd;
`endif

  // A request arriving on the committing edge is held for the following frame.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (commit_req) state_next = ST_PENDING;
      default: if (frame_edge && !commit_req) state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      vsync_q_reg <= 1'b0;
      wr_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      vsync_q_reg <= vsync;
      wr_err_reg  <= we && !addr_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi < NUM_SPRITES) begin : g_live
        logic [DATA_W-1:0] shadow_reg;
        logic [DATA_W-1:0] active_reg;
        logic              dirty_reg;
        logic              hit;

        assign hit = wr_ok && (waddr == ADDR_W'(gi));

        // Commit samples the pre-edge shadow, so a same-edge write stays dirty.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
            dirty_reg  <= 1'b0;
          end else begin
            if (do_commit) active_reg <= shadow_reg;
            if (hit) begin
              shadow_reg <= wdata;
              dirty_reg  <= 1'b1;
            end else if (do_commit) begin
              dirty_reg  <= 1'b0;
            end
          end
        end

        assign active_arr[gi] = active_reg;
        assign dirty_mask[gi] = dirty_reg;
      end else begin : g_pad
        assign active_arr[gi] = '0;
      end
    end
  endgenerate

  assign rd1            = active_arr[raddr1];
  assign rd2            = active_arr[raddr2];
  assign commit_pending = (state_reg == ST_PENDING);
  assign wr_err         = wr_err_reg;

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Directed bench for sprite_reg_bank with NUM_SPRITES=6 (non power of two),
// covering shadow/active separation, frame-edge commits and illegal indices.
module tb_sprite_reg_bank;

  localparam int N  = 6;
  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wd;
  logic          commit_req;
  logic          vsync;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          commit_pending;
  logic [N-1:0]  dirty_mask;
  logic          wr_err;

  int total;
  int bad;
  logic [DW-1:0] exp_act [N];

  sprite_reg_bank #(
    .NUM_SPRITES (N)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .we             (we),
    .waddr          (waddr),
    .wd             (wd),
    .commit_req     (commit_req),
    .vsync          (vsync),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rd1            (rd1),
    .rd2            (rd2),
    .commit_pending (commit_pending),
    .dirty_mask     (dirty_mask),
    .wr_err         (wr_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic rd1_chk(input string tag, input int a, input logic [DW-1:0] expv);
    raddr1 = AW'(a);
    #1;
    chk(tag, rd1, expv);
  endtask

  task automatic rd2_chk(input string tag, input int a, input logic [DW-1:0] expv);
    raddr2 = AW'(a);
    #1;
    chk(tag, rd2, expv);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    we    = 1'b1;
    waddr = AW'(a);
    wd    = d;
    tick();
    we    = 1'b0;
  endtask

  task automatic commit_now();
    commit_req = 1'b1;
    vsync      = 1'b0;
    tick();
    commit_req = 1'b0;
    tick();
    vsync      = 1'b1;
    tick();
    vsync      = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      rd1_chk(tag, i, exp_act[i]);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wd         = '0;
    commit_req = 1'b0;
    vsync      = 1'b0;
    raddr1     = '0;
    raddr2     = '0;
    for (int i = 0; i < N; i++) exp_act[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_pending", {31'b0, commit_pending}, 32'h0);
    chk("rst_dirty", {26'b0, dirty_mask}, 32'h0);
    chk("rst_wr_err", {31'b0, wr_err}, 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: shadow write is not visible before a commit
    wr(0, 32'h0010_0020);
    wr(2, 32'h0123_0456);
    rd1_chk("t1_rd1_hidden", 0, 32'h0);
    chk("t1_dirty", {26'b0, dirty_mask}, 32'h0000_0005);
    chk("t1_pending", {31'b0, commit_pending}, 32'h0);

    // 2: request, vsync rises five cycles later
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("t2_pending_set", {31'b0, commit_pending}, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_pending_hold", {31'b0, commit_pending}, 32'h1);
    rd1_chk("t2_rd1_before", 0, 32'h0);
    vsync = 1'b1;
    tick();
    exp_act[0] = 32'h0010_0020;
    exp_act[2] = 32'h0123_0456;
    rd1_chk("t2_rd1_after", 0, 32'h0010_0020);
    rd2_chk("t2_rd2_after", 2, 32'h0123_0456);
    chk("t2_dirty", {26'b0, dirty_mask}, 32'h0);
    chk("t2_pending_clr", {31'b0, commit_pending}, 32'h0);
    tick();
    chk("t2_no_retrigger", {31'b0, commit_pending}, 32'h0);
    vsync = 1'b0;
    tick();

    // 3: write landing on the committing edge
    wr(3, 32'h00AA_00BB);
    commit_now();
    exp_act[3] = 32'h00AA_00BB;
    rd1_chk("t3_pre", 3, 32'h00AA_00BB);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    vsync = 1'b1;
    wr(3, 32'h0005_0007);
    rd1_chk("t3_active_old", 3, 32'h00AA_00BB);
    chk("t3_dirty", {26'b0, dirty_mask}, 32'h0000_0008);
    chk("t3_pending", {31'b0, commit_pending}, 32'h0);
    commit_now();
    exp_act[3] = 32'h0005_0007;
    rd1_chk("t3_shadow_new", 3, 32'h0005_0007);
    chk("t3_dirty_clr", {26'b0, dirty_mask}, 32'h0);

    // commit_req and frame edge together in IDLE: defers to next frame
    wr(4, 32'h1111_2222);
    vsync = 1'b0;
    tick();
    commit_req = 1'b1;
    vsync      = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("idle_edge_pending", {31'b0, commit_pending}, 32'h1);
    rd1_chk("idle_edge_nocommit", 4, 32'h0);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    exp_act[4] = 32'h1111_2222;
    rd1_chk("idle_edge_commit", 4, 32'h1111_2222);
    chk("idle_edge_done", {31'b0, commit_pending}, 32'h0);
    vsync = 1'b0;

    // commit_req and frame edge together in PENDING: commit and stay pending
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wr(5, 32'h3333_4444);
    commit_req = 1'b1;
    vsync      = 1'b1;
    tick();
    commit_req = 1'b0;
    exp_act[5] = 32'h3333_4444;
    rd2_chk("pend_edge_commit", 5, 32'h3333_4444);
    chk("pend_edge_repend", {31'b0, commit_pending}, 32'h1);
    wr(5, 32'h5555_6666);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    exp_act[5] = 32'h5555_6666;
    rd2_chk("pend_edge_second", 5, 32'h5555_6666);
    chk("pend_edge_idle", {31'b0, commit_pending}, 32'h0);
    chk("pend_edge_dirty", {26'b0, dirty_mask}, 32'h0);

    // 4: illegal index write and out-of-range reads
    wr(6, 32'hDEAD_BEEF);
    chk("t4_wr_err_hi", {31'b0, wr_err}, 32'h1);
    chk("t4_dirty", {26'b0, dirty_mask}, 32'h0);
    tick();
    chk("t4_wr_err_lo", {31'b0, wr_err}, 32'h0);
    rd2_chk("t4_rd2_idx7", 7, 32'h0);
    rd2_chk("t4_rd2_idx6", 6, 32'h0);
    commit_now();
    check_all("t4_entries");

    // 5: reset while pending discards request and shadow data
    wr(1, 32'h7777_8888);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) exp_act[i] = '0;
    chk("t5_pending", {31'b0, commit_pending}, 32'h0);
    chk("t5_dirty", {26'b0, dirty_mask}, 32'h0);
    chk("t5_wr_err", {31'b0, wr_err}, 32'h0);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check_all("t5_no_commit");
    commit_now();
    check_all("t5_shadow_cleared");

    // 6: coordinate clamp (pass-through in the default build)
    wr(0, 32'h0300_0400);
    chk("t6_dirty", {26'b0, dirty_mask}, 32'h0000_0001);
    commit_now();
`ifdef SPRITE_COORD_CLAMP_EN
    rd1_chk("t6_clamp", 0, 32'h01DF_027F);
`else
    rd1_chk("t6_raw", 0, 32'h0300_0400);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
